y86_seq_controller: RTL and testbench

Multi-cycle sequencer for the Y86-64 sequential core. It steps fetch/decode/execute/memory/write_back through one stage per state and owns the PC, condition-code and status registers. It also multiplexes the single shared memory port between instruction fetch and data access with a req/ready handshake. This replaces free-running, clock-edge PC updates with explicit stage enables.

---
 rtl/y86_seq_controller.sv | 202 ++++++++++++++++++++
 tb/tb_y86_seq_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_controller.sv
// Multi-cycle Y86-64 sequencer: one stage per state, owns PC/CC/status and arbitrates the shared memory port.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step input and a PAUSE state after each instruction.
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic [63:0]      valM,
  input  logic [2:0]       out_CC,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             mem_err,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             mem_req,
  output logic             mem_is_fetch,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic [63:0]      pc,
  output logic [2:0]       cc,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int            TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PC_UPDATE,
    S_HALT,
    S_FAULT,
    S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       cc_q, cc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             uses_mem;

  assign uses_mem = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      cc_q      <= 3'b100;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cc_q      <= cc_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cc_d         = cc_q;
    stat_d       = stat_q;
    retired_d    = retired_q;
    tmo_d        = tmo_q;
    mem_req      = 1'b0;
    mem_is_fetch = 1'b0;
    f_en         = 1'b0;
    d_en         = 1'b0;
    e_en         = 1'b0;
    m_en         = 1'b0;
    w_en         = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        f_en         = 1'b1;
        if (mem_ready) begin
          if (mem_err) begin
            state_d = S_FAULT;
            stat_d  = STAT_ADR;
          end else if (!instr_valid) begin
            state_d = S_FAULT;
            stat_d  = STAT_INS;
          end else if (icode == 4'h0) begin
            state_d = S_HALT;
            stat_d  = STAT_HLT;
          end else begin
            state_d = S_DECODE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DECODE: begin
        d_en    = 1'b1;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        e_en = 1'b1;
        if (icode == 4'h6) begin
          cc_d = out_CC;
        end
        state_d = uses_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        m_en    = 1'b1;
        if (mem_ready) begin
          if (mem_err) begin
            state_d = S_FAULT;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITEBACK: begin
        w_en    = 1'b1;
        state_d = S_PC_UPDATE;
      end
      S_PC_UPDATE: begin
        if ((icode == 4'h7 && cnd) || icode == 4'h8) begin
          pc_d = valC;
        end else if (icode == 4'h9) begin
          pc_d = valM;
        end else begin
          pc_d = valP;
        end
        retired_d = retired_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
        state_d = S_PAUSE;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end
`endif
      default: begin
      end
    endcase

    // Every new state starts its memory wait budget from zero.
    if (state_d != state_q) begin
      tmo_d = '0;
    end

    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_is_fetch = 1'b0;
      f_en         = 1'b0;
      d_en         = 1'b0;
      e_en         = 1'b0;
      m_en         = 1'b0;
      w_en         = 1'b0;
    end
  end

  assign pc      = pc_q;
  assign cc      = cc_q;
  assign stat    = stat_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Bench for y86_seq_controller: an instruction-level model expands each instruction into its expected
// per-cycle outputs; a single negedge process compares the DUT against that stream.
module tb_y86_seq_controller;

  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam int          T        = 16;

  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_F    = 5'b10000;
  localparam logic [4:0] EN_D    = 5'b01000;
  localparam logic [4:0] EN_E    = 5'b00100;
  localparam logic [4:0] EN_M    = 5'b00010;
  localparam logic [4:0] EN_W    = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  icode = '0;
  logic        cnd = 1'b0;
  logic [63:0] valC = '0, valP = '0, valM = '0;
  logic [2:0]  out_CC = '0;
  logic        instr_valid = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_err = 1'b0;
  logic        mem_req, mem_is_fetch, f_en, d_en, e_en, m_en, w_en;
  logic [63:0] pc;
  logic [2:0]  cc, stat;
  logic [31:0] retired;

  always #5 clk = ~clk;

  y86_seq_controller #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .cnd(cnd), .valC(valC), .valP(valP),
    .valM(valM), .out_CC(out_CC), .instr_valid(instr_valid), .mem_ready(mem_ready),
    .mem_err(mem_err), .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .f_en(f_en),
    .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc(pc), .cc(cc),
    .stat(stat), .retired(retired)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  icode;
    logic        valid;
    logic        cnd;
    logic [63:0] valc, valp, valm;
    logic [2:0]  occ;
    logic        rdy, err;
    logic [4:0]  en;
    logic        req, isf;
    logic [63:0] pc;
    logic [2:0]  cc, stat;
    logic [31:0] ret;
  } rec_t;

  typedef struct {
    int          id;
    logic [63:0] act, exp;
  } lit_t;

  rec_t seq[$];
  rec_t exp_q[$];
  lit_t lit_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] m_pc;
  logic [2:0]  m_cc, m_stat;
  logic [31:0] m_ret;
  bit          m_term;

  logic [3:0]  c_icode;
  logic        c_valid, c_cnd;
  logic [63:0] c_valc, c_valp, c_valm;
  logic [2:0]  c_occ;

  function automatic string lit_name(input int id);
    case (id)
      0: return "lat_irmovq";
      1: return "halt_pc";
      2: return "halt_stat";
      3: return "halt_retired";
      4: return "opq_cc";
      5: return "nop_keeps_cc";
      6: return "jxx_taken_pc";
      7: return "jxx_not_taken_pc";
      8: return "lat_ret_3wait";
      9: return "ret_pc";
      10: return "timeout_cycles";
      11: return "timeout_stat";
      12: return "abort_pc";
      default: return "abort_cc";
    endcase
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void lit(input int id, input logic [63:0] act, input logic [63:0] exp);
    lit_t l;
    l.id = id; l.act = act; l.exp = exp;
    lit_q.push_back(l);
  endfunction

  function automatic void push(input logic [4:0] en, input logic req, input logic isf,
                               input logic rdy, input logic err, input logic rst);
    rec_t r;
    r.rst = rst; r.icode = c_icode; r.valid = c_valid; r.cnd = c_cnd;
    r.valc = c_valc; r.valp = c_valp; r.valm = c_valm; r.occ = c_occ;
    r.rdy = rdy; r.err = err; r.en = en; r.req = req; r.isf = isf;
    r.pc = m_pc; r.cc = m_cc; r.stat = m_stat; r.ret = m_ret;
    seq.push_back(r);
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC; m_cc = 3'b100; m_stat = 3'd1; m_ret = '0; m_term = 1'b0;
  endfunction

  function automatic void do_reset();
    push(EN_NONE, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    model_reset();
  endfunction

  // Waits on a memory access; returns 1 when the access ran out of budget.
  function automatic bit mem_wait(input logic [4:0] en, input logic isf, input int waits);
    for (int w = 0; w < waits && w < T; w++)
      push(en, 1'b1, isf, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    if (waits >= T) begin
      m_stat = 3'd3; m_term = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic gen_instr(input logic [3:0] ic, input logic valid, input logic cn,
                           input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                           input logic [2:0] occ, input int fw, input logic ferr,
                           input int mw, input logic merr);
    c_icode = ic; c_valid = valid; c_cnd = cn; c_valc = vc; c_valp = vp; c_valm = vm; c_occ = occ;
    if (mem_wait(EN_F, 1'b1, fw)) return;
    push(EN_F, 1'b1, 1'b1, 1'b1, ferr, 1'b0);
    if (ferr) begin m_stat = 3'd3; m_term = 1'b1; return; end
    if (!valid) begin m_stat = 3'd4; m_term = 1'b1; return; end
    if (ic == 4'h0) begin m_stat = 3'd2; m_term = 1'b1; return; end
    push(EN_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(EN_E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ic == 4'h6) m_cc = occ;
    if (ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) begin
      if (mem_wait(EN_M, 1'b0, mw)) return;
      push(EN_M, 1'b1, 1'b0, 1'b1, merr, 1'b0);
      if (merr) begin m_stat = 3'd3; m_term = 1'b1; return; end
    end
    push(EN_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(EN_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (ic == 4'h7) m_pc = cn ? vc : vp;
    else if (ic == 4'h8) m_pc = vc;
    else if (ic == 4'h9) m_pc = vm;
    else m_pc = vp;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic terminal(input int n);
    for (int i = 0; i < n; i++)
      push(EN_NONE, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic apply();
    rec_t r;
    while (seq.size() > 0) begin
      r = seq.pop_front();
      @(posedge clk);
      #1;
      rst_n = !r.rst; icode = r.icode; instr_valid = r.valid; cnd = r.cnd;
      valC = r.valc; valP = r.valp; valM = r.valm; out_CC = r.occ;
      mem_ready = r.rdy; mem_err = r.err;
      exp_q.push_back(r);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin : cmp
    rec_t r;
    lit_t l;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("enables", 64'({f_en, d_en, e_en, m_en, w_en}), 64'(r.en));
      chk("mem_req", 64'(mem_req), 64'(r.req));
      if (r.req) chk("mem_is_fetch", 64'(mem_is_fetch), 64'(r.isf));
      chk("pc", pc, r.pc);
      chk("cc", 64'(cc), 64'(r.cc));
      chk("stat", 64'(stat), 64'(r.stat));
      chk("retired", 64'(retired), 64'(r.ret));
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      chk(lit_name(l.id), l.act, l.exp);
    end
  end

  initial begin
    int n0;
    rec_t r;
    c_icode = '0; c_valid = 1'b1; c_cnd = 1'b0; c_valc = '0; c_valp = '0; c_valm = '0; c_occ = '0;
    model_reset();

    // irmovq then halt with zero-wait memory
    do_reset();
    n0 = seq.size();
    gen_instr(4'h3, 1'b1, 1'b0, 64'd5, 64'd76, 64'd0, 3'b111, 0, 1'b0, 0, 1'b0);
    lit(0, 64'(seq.size() - n0), 64'd5);
    gen_instr(4'h0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 3'b000, 0, 1'b0, 0, 1'b0);
    lit(1, m_pc, 64'd76);
    lit(2, 64'(m_stat), 64'd2);
    lit(3, 64'(m_ret), 64'd1);
    terminal(3);
    apply();

    // OPq / nop condition codes, jumps, ret with memory waits, fetch timeout
    do_reset();
    gen_instr(4'h6, 1'b1, 1'b0, 64'd1, 64'd10, 64'd0, 3'b010, 0, 1'b0, 0, 1'b0);
    lit(4, 64'(m_cc), 64'b010);
    gen_instr(4'h1, 1'b1, 1'b0, 64'd1, 64'd11, 64'd0, 3'b101, 1, 1'b0, 0, 1'b0);
    lit(5, 64'(m_cc), 64'b010);
    gen_instr(4'h7, 1'b1, 1'b1, 64'd200, 64'd73, 64'd0, 3'b001, 0, 1'b0, 0, 1'b0);
    lit(6, m_pc, 64'd200);
    gen_instr(4'h7, 1'b1, 1'b0, 64'd200, 64'd73, 64'd0, 3'b001, 0, 1'b0, 0, 1'b0);
    lit(7, m_pc, 64'd73);
    n0 = seq.size();
    gen_instr(4'h9, 1'b1, 1'b0, 64'd9, 64'd74, 64'h40, 3'b001, 0, 1'b0, 3, 1'b0);
    lit(8, 64'(seq.size() - n0), 64'd9);
    lit(9, m_pc, 64'h40);
    n0 = seq.size();
    gen_instr(4'h3, 1'b1, 1'b0, 64'd1, 64'd2, 64'd3, 3'b000, 30, 1'b0, 0, 1'b0);
    lit(10, 64'(seq.size() - n0), 64'd16);
    lit(11, 64'(m_stat), 64'd3);
    terminal(4);
    apply();

    // reset asserted during a MEMORY wait
    do_reset();
    gen_instr(4'h6, 1'b1, 1'b0, 64'd1, 64'd20, 64'd0, 3'b010, 0, 1'b0, 0, 1'b0);
    n0 = seq.size();
    gen_instr(4'h9, 1'b1, 1'b0, 64'd1, 64'd30, 64'h80, 3'b000, 0, 1'b0, 5, 1'b0);
    r = seq[n0 + 4];
    r.rst = 1'b1; r.en = EN_NONE; r.req = 1'b0; r.isf = 1'b0;
    while (seq.size() > n0 + 4) void'(seq.pop_back());
    seq.push_back(r);
    model_reset();
    lit(12, m_pc, RESET_PC);
    lit(13, 64'(m_cc), 64'b100);
    gen_instr(4'h1, 1'b1, 1'b0, 64'd0, 64'h1002, 64'd0, 3'b000, 0, 1'b0, 0, 1'b0);
    gen_instr(4'h0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 3'b000, 0, 1'b0, 0, 1'b0);
    terminal(2);
    apply();

    // randomized programs
    for (int p = 0; p < 40; p++) begin
      do_reset();
      for (int k = 0; k < 12 && !m_term; k++) begin
        gen_instr(($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 11)),
                  1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                  rnd64(), rnd64(), rnd64(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 3),
                  1'($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 19) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 3),
                  1'($urandom_range(0, 24) == 0));
      end
      if (m_term) terminal(3);
      apply();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
